vga_sync_gen: RTL and testbench
===============================

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 SHALL provide parameter H_SYNC, default 96, hsync pulse width in pixels.
REQ-002 SHALL provide parameter H_BP, default 48, horizontal back porch in pixels.
REQ-003 SHALL provide parameter H_ACT, default 640, horizontal active pixels.
REQ-004 SHALL provide parameter H_TOTAL, default 800, pixels per line.
REQ-005 SHALL provide parameter V_SYNC, default 2, vsync pulse width in lines.
REQ-006 SHALL provide parameter V_BP, default 33, vertical back porch in lines.
REQ-007 SHALL provide parameter V_ACT, default 480, active lines.
REQ-008 SHALL provide parameter V_TOTAL, default 525, lines per frame.
REQ-009 SHALL have port clk, input, 1, board clock at 50 MHz (2x pixel rate), the single clock.
REQ-010 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-011 SHALL have port HCounter, output, 10, horizontal pixel count, 0 = start of hsync pulse.
REQ-012 SHALL have port VCounter, output, 10, vertical line count, 0 = start of vsync pulse.
REQ-013 SHALL have port hsync, output, 1, horizontal sync, active low.
REQ-014 SHALL have port vsync, output, 1, vertical sync, active low.
REQ-015 SHALL have port video_on, output, 1, high inside the active window.
REQ-016 SHALL have port pix_tick, output, 1, pixel-rate enable, high every second clk.
REQ-017 SHALL have port frame_start, output, 1, one-clk pulse at the first pixel tick of each frame.

Function
REQ-018 pix_tick SHALL toggle on every clk edge; HCounter/VCounter SHALL change only on edges where pix_tick is 1.
REQ-019 HCounter SHALL increment by 1 per pixel tick and wrap from H_TOTAL-1 (799) to 0.
REQ-020 VCounter SHALL increment by 1 only on the tick where HCounter wraps 799->0, and wrap from V_TOTAL-1 (524) to 0 on that same tick.
REQ-021 hsync SHALL be 0 when HCounter < H_SYNC (0..95), else 1.
REQ-022 vsync SHALL be 0 when VCounter < V_SYNC (0..1), else 1.
REQ-023 video_on SHALL be 1 iff H_SYNC+H_BP <= HCounter < H_SYNC+H_BP+H_ACT (144..783) and V_SYNC+V_BP <= VCounter < V_SYNC+V_BP+V_ACT (35..514).
REQ-024 hsync, vsync and video_on SHALL be registered and always consistent with the HCounter/VCounter values presented in the same cycle (zero relative skew).
REQ-025 frame_start SHALL be 1 exactly in the clk cycle where pix_tick=1, HCounter=0 and VCounter=0; 0 otherwise.
REQ-026 All comparisons SHALL be unsigned 10-bit; counters SHALL never exceed H_TOTAL-1 / V_TOTAL-1.
REQ-027 Downstream draw stages consume HCounter/VCounter combinationally; outputs SHALL be glitch-free registers.

Reset
REQ-028 While reset=1 at a clk edge: HCounter=0, VCounter=0, pix_tick=0, hsync=0, vsync=0, video_on=0, frame_start=0.
REQ-029 Reset asserted mid-line or mid-frame SHALL abandon the frame; first cycle after release SHALL present the reset values, and frame_start SHALL pulse on the following cycle (first pix_tick=1).

Structure
REQ-030 Timing constants (H_SYNC..V_TOTAL and derived active-window bounds) SHALL live in a shared package vga_timing_pkg used by all draw stages.
REQ-031 The clk/2 enable SHALL be a sub-module pix_tick_gen; counters and sync decode stay in vga_sync_gen.

Verification
REQ-032 Reset release -> cycle 0: pix_tick=0, H=0, V=0; cycle 1: pix_tick=1, frame_start=1; cycle 3: H=1.
REQ-033 Run one line -> hsync low for exactly 192 clk, line period exactly 1600 clk; H 799->0 increments V.
REQ-034 Run full frame -> vsync low for 2 lines (3200 clk), frame period 840000 clk, frame_start pulses exactly once per frame.
REQ-035 Sample video_on -> first high at H=144,V=35; last high at H=783,V=514; 307200 active pixel ticks per frame.
REQ-036 Assert reset at H=500,V=300 for 3 clk -> counters return to 0 and REQ-032 sequence repeats.
REQ-037 Drive draw stage with counters at V=456,H=464 -> video_on=1, hsync=1, vsync=1.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared 640x480@60 timing constants, window bounds
// and small counter helpers for the sync generator and draw stages.
package vga_timing_pkg;

    localparam int unsigned CNT_W = 10;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam int unsigned VGA_H_SYNC  = 96;
    localparam int unsigned VGA_H_BP    = 48;
    localparam int unsigned VGA_H_ACT   = 640;
    localparam int unsigned VGA_H_TOTAL = 800;

    localparam int unsigned VGA_V_SYNC  = 2;
    localparam int unsigned VGA_V_BP    = 33;
    localparam int unsigned VGA_V_ACT   = 480;
    localparam int unsigned VGA_V_TOTAL = 525;

    // Active window, half-open [LO, HI)
    localparam int unsigned VGA_H_ACT_LO = VGA_H_SYNC + VGA_H_BP;
    localparam int unsigned VGA_H_ACT_HI = VGA_H_ACT_LO + VGA_H_ACT;
    localparam int unsigned VGA_V_ACT_LO = VGA_V_SYNC + VGA_V_BP;
    localparam int unsigned VGA_V_ACT_HI = VGA_V_ACT_LO + VGA_V_ACT;

    function automatic logic in_win(
        input cnt_t c,
        input cnt_t lo,
        input cnt_t hi
    );
        return (c >= lo) && (c < hi);
    endfunction

    function automatic cnt_t wrap_inc(
        input cnt_t c,
        input cnt_t last
    );
        return (c == last) ? '0 : c + cnt_t'(1);
    endfunction

endpackage

// File: rtl/vga_sync_gen_pix_tick_gen.sv
// pix_tick_gen: clk/2 pixel enable, low in the first cycle after reset.
// Ports: clk, reset (sync, active high), o_pix_tick.
module pix_tick_gen (
    input  logic clk,
    input  logic reset,
    output logic o_pix_tick
);

    logic r_tick;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick <= 1'b0;
        end else begin
            r_tick <= ~r_tick;
        end
    end

    assign o_pix_tick = r_tick;

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: pixel/line counters with registered sync, window and
// frame-start decode. Ports: clk, reset, HCounter, VCounter, hsync,
// vsync, video_on, pix_tick, frame_start.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_SYNC  = VGA_H_SYNC,
    parameter int unsigned H_BP    = VGA_H_BP,
    parameter int unsigned H_ACT   = VGA_H_ACT,
    parameter int unsigned H_TOTAL = VGA_H_TOTAL,
    parameter int unsigned V_SYNC  = VGA_V_SYNC,
    parameter int unsigned V_BP    = VGA_V_BP,
    parameter int unsigned V_ACT   = VGA_V_ACT,
    parameter int unsigned V_TOTAL = VGA_V_TOTAL
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] HCounter,
    output logic [9:0] VCounter,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       pix_tick,
    output logic       frame_start
);

    localparam cnt_t H_LAST = cnt_t'(H_TOTAL - 1);
    localparam cnt_t V_LAST = cnt_t'(V_TOTAL - 1);
    localparam cnt_t HS_END = cnt_t'(H_SYNC);
    localparam cnt_t VS_END = cnt_t'(V_SYNC);
    localparam cnt_t H_LO   = cnt_t'(H_SYNC + H_BP);
    localparam cnt_t H_HI   = cnt_t'(H_SYNC + H_BP + H_ACT);
    localparam cnt_t V_LO   = cnt_t'(V_SYNC + V_BP);
    localparam cnt_t V_HI   = cnt_t'(V_SYNC + V_BP + V_ACT);

    logic w_tick;
    cnt_t w_h_nxt;
    cnt_t w_v_nxt;

    cnt_t r_h;
    cnt_t r_v;
    logic r_hs;
    logic r_vs;
    logic r_von;
    logic r_fs;

    pix_tick_gen u_tick (
        .clk        (clk),
        .reset      (reset),
        .o_pix_tick (w_tick)
    );

    always_comb begin
        w_h_nxt = r_h;
        w_v_nxt = r_v;
        if (w_tick) begin
            w_h_nxt = wrap_inc(r_h, H_LAST);
            if (r_h == H_LAST) begin
                w_v_nxt = wrap_inc(r_v, V_LAST);
            end
        end
    end

    // Decode from the next counter values so the registered flags
    // line up with the counters they describe in the same cycle.
    // Next tick is ~w_tick, hence the inversion in frame_start.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_h   <= '0;
            r_v   <= '0;
            r_hs  <= 1'b0;
            r_vs  <= 1'b0;
            r_von <= 1'b0;
            r_fs  <= 1'b0;
        end else begin
            r_h   <= w_h_nxt;
            r_v   <= w_v_nxt;
            r_hs  <= (w_h_nxt >= HS_END);
            r_vs  <= (w_v_nxt >= VS_END);
            r_von <= in_win(w_h_nxt, H_LO, H_HI) &&
                     in_win(w_v_nxt, V_LO, V_HI);
            r_fs  <= ~w_tick && (w_h_nxt == '0) &&
                     (w_v_nxt == '0);
        end
    end

    assign HCounter    = r_h;
    assign VCounter    = r_v;
    assign hsync       = r_hs;
    assign vsync       = r_vs;
    assign video_on    = r_von;
    assign pix_tick    = w_tick;
    assign frame_start = r_fs;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: random-reset bench for a shrunk-timing instance
// and a default-timing instance, checked against an arithmetic model.
module tb_vga_sync_gen;

    localparam int unsigned SH_SYNC  = 4;
    localparam int unsigned SH_BP    = 3;
    localparam int unsigned SH_ACT   = 10;
    localparam int unsigned SH_TOTAL = 20;
    localparam int unsigned SV_SYNC  = 2;
    localparam int unsigned SV_BP    = 2;
    localparam int unsigned SV_ACT   = 6;
    localparam int unsigned SV_TOTAL = 12;
    localparam int unsigned S_FRAME  = 2 * SH_TOTAL * SV_TOTAL;

    localparam int unsigned DIR_CYC  = 4000;
    localparam int unsigned RND_CYC  = 40000;

    typedef struct packed {
        logic       pt;
        logic [9:0] h;
        logic [9:0] v;
        logic       hs;
        logic       vs;
        logic       von;
        logic       fs;
    } exp_t;

    logic clk;
    logic reset;

    logic [9:0] s_h, s_v, d_h, d_v;
    logic s_hs, s_vs, s_von, s_pt, s_fs;
    logic d_hs, d_vs, d_von, d_pt, d_fs;

    int unsigned n;
    int n_cmp;
    int n_err;

    int unsigned s_act, s_fcnt, d_fcnt, d_hlow, d_vlow;

    vga_sync_gen #(
        .H_SYNC  (SH_SYNC),
        .H_BP    (SH_BP),
        .H_ACT   (SH_ACT),
        .H_TOTAL (SH_TOTAL),
        .V_SYNC  (SV_SYNC),
        .V_BP    (SV_BP),
        .V_ACT   (SV_ACT),
        .V_TOTAL (SV_TOTAL)
    ) u_small (
        .clk         (clk),
        .reset       (reset),
        .HCounter    (s_h),
        .VCounter    (s_v),
        .hsync       (s_hs),
        .vsync       (s_vs),
        .video_on    (s_von),
        .pix_tick    (s_pt),
        .frame_start (s_fs)
    );

    vga_sync_gen u_dflt (
        .clk         (clk),
        .reset       (reset),
        .HCounter    (d_h),
        .VCounter    (d_v),
        .hsync       (d_hs),
        .vsync       (d_vs),
        .video_on    (d_von),
        .pix_tick    (d_pt),
        .frame_start (d_fs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // n = clk cycles since the first cycle after reset release.
    // Each pixel lasts two cycles: tick low, then tick high.
    function automatic exp_t ref_at(
        input int unsigned cyc,
        input int unsigned hsy, input int unsigned hbp,
        input int unsigned hac, input int unsigned hto,
        input int unsigned vsy, input int unsigned vbp,
        input int unsigned vac, input int unsigned vto
    );
        exp_t e;
        int unsigned p, h, v;
        p     = cyc / 2;
        h     = p % hto;
        v     = (p / hto) % vto;
        e.pt  = (cyc % 2) == 1;
        e.h   = 10'(h);
        e.v   = 10'(v);
        e.hs  = h >= hsy;
        e.vs  = v >= vsy;
        e.von = (h >= hsy + hbp) && (h < hsy + hbp + hac) &&
                (v >= vsy + vbp) && (v < vsy + vbp + vac);
        e.fs  = e.pt && (h == 0) && (v == 0);
        return e;
    endfunction

    task automatic chk(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] want
    );
        n_cmp++;
        if (obs !== want) begin
            n_err++;
            $display("FAIL %s @n=%0d: got %0h want %0h",
                     tag, n, obs, want);
        end
    endtask

    task automatic chk_dut(
        input string pfx, input exp_t e,
        input logic pt, input logic [9:0] h,
        input logic [9:0] v, input logic hs,
        input logic vs, input logic von, input logic fs
    );
        chk({pfx, ".pix_tick"},    32'(pt),  32'(e.pt));
        chk({pfx, ".HCounter"},    32'(h),   32'(e.h));
        chk({pfx, ".VCounter"},    32'(v),   32'(e.v));
        chk({pfx, ".hsync"},       32'(hs),  32'(e.hs));
        chk({pfx, ".vsync"},       32'(vs),  32'(e.vs));
        chk({pfx, ".video_on"},    32'(von), 32'(e.von));
        chk({pfx, ".frame_start"}, 32'(fs),  32'(e.fs));
    endtask

    task automatic step();
        exp_t es, ed;
        @(posedge clk);
        n = reset ? 0 : n + 1;
        @(negedge clk);
        es = ref_at(n, SH_SYNC, SH_BP, SH_ACT, SH_TOTAL,
                    SV_SYNC, SV_BP, SV_ACT, SV_TOTAL);
        ed = ref_at(n, 96, 48, 640, 800, 2, 33, 480, 525);
        chk_dut("small", es, s_pt, s_h, s_v, s_hs, s_vs,
                s_von, s_fs);
        chk_dut("dflt", ed, d_pt, d_h, d_v, d_hs, d_vs,
                d_von, d_fs);
    endtask

    task automatic tally();
        if (n < S_FRAME && s_von && s_pt) s_act++;
        if (s_fs) s_fcnt++;
        if (d_fs) d_fcnt++;
        if (n < 1600 && !d_hs) d_hlow++;
        if (n < 3400 && !d_vs) d_vlow++;
    endtask

    initial begin
        int unsigned rst_left;
        n_cmp   = 0;
        n_err   = 0;
        n       = 0;
        s_act   = 0;
        s_fcnt  = 0;
        d_fcnt  = 0;
        d_hlow  = 0;
        d_vlow  = 0;
        reset   = 1'b1;

        repeat (3) step();
        reset = 1'b0;
        tally();
        for (int i = 1; i < int'(DIR_CYC); i++) begin
            step();
            tally();
        end

        chk("small.active_ticks", s_act, SH_ACT * SV_ACT);
        chk("small.frame_pulses", s_fcnt,
            (DIR_CYC - 2) / S_FRAME + 1);
        chk("dflt.frame_pulses", d_fcnt, 1);
        chk("dflt.hsync_low_clk", d_hlow, 2 * 96);
        chk("dflt.vsync_low_clk", d_vlow, 2 * 2 * 800);

        rst_left = 0;
        for (int i = 0; i < int'(RND_CYC); i++) begin
            if (rst_left > 0) begin
                reset    = 1'b1;
                rst_left = rst_left - 1;
            end else if ($urandom_range(0, 7999) == 0) begin
                reset    = 1'b1;
                rst_left = $urandom_range(0, 3);
            end else begin
                reset = 1'b0;
            end
            step();
        end

        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
